mdc_in_reorder: RTL

MDC_IN_REORDER -- requirements
Module: mdc_in_reorder

---
 rtl/mdc_in_reorder.sv | 100 ++++++++++
 1 files changed

// File: rtl/mdc_in_reorder.sv
// mdc_in_reorder: ping-pong frame buffer that turns a serial complex stream into LANES-wide MDC beats.
// Optional REORDER_ERR_EN adds frame_err_o and restarts the frame on a misaligned start.
module mdc_in_reorder #(
  parameter int NB = 16,
  parameter int NPT = 32,
  parameter int LANES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                valid_i,
  input  logic [NB-1:0]       dr_i,
  input  logic [NB-1:0]       di_i,
  output logic                start_mdc_o,
  output logic                valid_o,
  output logic [LANES*NB-1:0] dr_mdc_o,
  output logic [LANES*NB-1:0] di_mdc_o
`ifdef REORDER_ERR_EN
  ,
  output logic                frame_err_o
`endif
);
  localparam int D = NPT / LANES;
  localparam int WW = $clog2(NPT);
  localparam int DW = $clog2(D);
  localparam int LW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, ARM, READ} state_t;
  state_t state, state_n;
  logic [DW-1:0] k, k_n;
  logic [WW-1:0] w, widx;
  logic synced, wbank, rbank, pend, pend_bank, wr_en, restart, handoff, take;
  logic [2*NB-1:0] mem [2*NPT];
`ifdef REORDER_ERR_EN
  assign restart = start_i && (!synced || w != '0);
`else
  assign restart = start_i && !synced;
`endif
  assign wr_en = valid_i && (synced || start_i);
  assign widx = restart ? '0 : w;
  assign handoff = wr_en && widx == WW'(NPT - 1);
  assign take = state_n == ARM;
  // Address {bank, w} places sample w in sub-bank w/D at word w%D.
  always_ff @(posedge clk_i)
    if (wr_en) mem[{wbank, widx}] <= {dr_i, di_i};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      synced <= 1'b0;
      w <= '0;
      wbank <= 1'b0;
      pend <= 1'b0;
      pend_bank <= 1'b0;
    end else begin
      if (wr_en) begin
        synced <= 1'b1;
        w <= widx + 1'b1;
        if (handoff) wbank <= ~wbank;
      end
      pend <= handoff || (pend && !take);
      if (handoff) pend_bank <= wbank;
    end
`ifdef REORDER_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) frame_err_o <= 1'b0;
    else frame_err_o <= valid_i && start_i && synced && w != '0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      k <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
    end
  always_comb begin
    state_n = state;
    k_n = k;
    start_mdc_o = state == ARM;
    valid_o = state == READ;
    if (state == IDLE && pend) state_n = ARM;
    else if (state == ARM) begin
      state_n = READ;
      k_n = '0;
    end else if (state == READ) begin
      k_n = k + 1'b1;
      if (k == DW'(D - 1)) state_n = pend ? ARM : IDLE;
    end
  end
  // Lane j reads sub-bank LANES-1-j so the MSB lane carries sample k.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rbank <= 1'b0;
      dr_mdc_o <= '0;
      di_mdc_o <= '0;
    end else begin
      if (take) rbank <= pend_bank;
      if (state_n == READ)
        for (int j = 0; j < LANES; j++)
          {dr_mdc_o[j*NB +: NB], di_mdc_o[j*NB +: NB]} <= mem[{rbank, LW'(LANES - 1 - j), k_n}];
    end
endmodule
